escalonador_paradas: RTL
========================

Name: escalonador_paradas

Overview:
- Stop scheduler for the SmartCargo lift. It queues up to N_SLOTS origin→destination cargo requests from the call buttons.
- It picks the next stop using a SCAN (elevator) policy and hands it to the movement controller as proxParada/temDestino/sobe.
- It sequences unload (tira_objetos) then load (coloca_objetos) at each stop.
- It sits between the button inputs and the movement controller/datapath and replaces the shift-RAM destination list.

Parameters:
N_SLOTS, 4, number of outstanding request slots (2..8).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
novo_pedido  in  1  one-cycle pulse; origemBot/destinoBot valid this cycle
origemBot  in  4  one-hot pickup floor
destinoBot  in  4  one-hot drop floor
andarAtual  in  2  binary current floor (0..3)
chegou  in  1  pulse: cab stopped at andarAtual
servico_feito  in  1  pulse: current load/unload finished
emergencia  in  1  level: freeze scheduling
pedido_aceito  out  1  one-cycle pulse
pedido_rejeitado  out  1  one-cycle pulse
proxParada  out  2  registered target floor
temDestino  out  1  target valid, cab should move or stop
sobe  out  1  SCAN direction, 1 = up
tira_objetos  out  1  level: unloading at current stop
coloca_objetos  out  1  level: loading at current stop
slots_ocupados  out  4  number of non-free slots
db_estado  out  4  FSM state code

Behaviour:
- Reset (async): all slots LIVRE, state OCIOSO, sobe=1, proxParada=0, temDestino=0, tira/coloca=0, accept/reject pulses=0, slots_ocupados=0.
- Slot states: LIVRE, ESPERA (awaiting pickup at origem), CARREGADO (awaiting drop at destino). Each slot stores origem and destino as 2-bit binary.
- Request check, sampled when novo_pedido=1. A request is valid only if origemBot and destinoBot are each exactly one-hot and origem≠destino.
  - Valid, a free slot exists, and not EMERGENCIA: write the lowest-index LIVRE slot to ESPERA and pulse pedido_aceito on the next cycle.
  - Otherwise: pulse pedido_rejeitado on the next cycle, with no slot change.
  - Duplicate requests occupy separate slots.
  - A slot freed in the same cycle is not visible to that request, so it is rejected if the queue was full.
- Stop map paradas[f] (combinational) = any ESPERA slot with origem=f OR any CARREGADO slot with destino=f.
- FSM codes: OCIOSO=0, DESPACHA=1, AGUARDA=2, TIRA=3, COLOCA=4, EMERG=5.
- OCIOSO: temDestino=0. If paradas≠0, go to DESPACHA.
- DESPACHA (1 cycle), target selection in priority order:
  1. paradas[andarAtual].
  2. The nearest set floor in direction sobe.
  3. Otherwise toggle sobe and take the nearest set floor in the new direction.
  - Register proxParada, set temDestino=1, go to AGUARDA.
- AGUARDA:
  - chegou with andarAtual==proxParada: go to TIRA.
  - chegou at any other floor is ignored.
  - No retargeting while in AGUARDA.
- TIRA:
  - If no CARREGADO slot has destino=andarAtual, go to COLOCA in 1 cycle with tira_objetos=0.
  - Otherwise hold tira_objetos=1 until servico_feito. On that cycle, free every matching CARREGADO slot and go to COLOCA.
- COLOCA:
  - Same pattern for ESPERA slots with origem=andarAtual: hold coloca_objetos=1 until servico_feito.
  - On servico_feito, move every matching slot to CARREGADO, clear temDestino, and go to OCIOSO.
  - A request accepted during COLOCA stays ESPERA. It is served by the next DESPACHA (current-floor priority).
- EMERG:
  - Entered from any state while emergencia=1, with highest priority.
  - temDestino, tira and coloca are forced to 0. Slots and sobe are retained. New requests are rejected.
  - On deassertion go to OCIOSO, so a fresh DESPACHA runs.
- Ignored inputs: servico_feito outside TIRA/COLOCA, and chegou outside AGUARDA.
- slots_ocupados is registered and updates the cycle after any slot change.

Test Plan:
- Reset mid-AGUARDA with 2 slots busy → all outputs return to reset values immediately; slots_ocupados=0.
- Single request origem=0001, destino=1000 with andarAtual=2:
  - pedido_aceito pulses.
  - DESPACHA: sobe=1, nothing above carries a stop, so sobe toggles to 0 and proxParada=0.
  - chegou@0 → coloca_objetos=1 → servico_feito.
  - Next DESPACHA: proxParada=3, sobe=1.
  - chegou@3 → tira_objetos=1 → servico_feito → slots_ocupados=0.
- Invalid inputs:
  - origemBot=0011 → pedido_rejeitado.
  - origem=destino=0100 → pedido_rejeitado.
  - Fill N_SLOTS=4, then a fifth valid request → pedido_rejeitado, slots_ocupados=4.
- SCAN order: cab at 1 going up, pending stops at 0, 2 and 3 → served in order 2, 3, 0.
- Combined stop: at floor 2, one slot drops at 2 and another picks up at 2 → tira_objetos phase, then coloca_objetos phase, each ended by servico_feito. slots_ocupados goes 2→1 after unload, stays 1 after load.
- Emergency during AGUARDA:
  - temDestino drops the next cycle; a request during emergency → rejected.
  - On release: DESPACHA, same proxParada re-issued, slots intact.

Source files
------------

// File: rtl/escalonador_paradas.sv
// SmartCargo stop scheduler: queues origin->destination cargo requests and picks the
// next stop with a SCAN policy, sequencing unload then load at each stop.
module escalonador_paradas #(
  parameter int unsigned N_SLOTS = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       novo_pedido,
  input  logic [3:0] origemBot,
  input  logic [3:0] destinoBot,
  input  logic [1:0] andarAtual,
  input  logic       chegou,
  input  logic       servico_feito,
  input  logic       emergencia,
  output logic       pedido_aceito,
  output logic       pedido_rejeitado,
  output logic [1:0] proxParada,
  output logic       temDestino,
  output logic       sobe,
  output logic       tira_objetos,
  output logic       coloca_objetos,
  output logic [3:0] slots_ocupados,
  output logic [3:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO = 3'd0, DESPACHA = 3'd1, AGUARDA = 3'd2,
    TIRA = 3'd3, COLOCA = 3'd4, EMERG = 3'd5
  } estado_t;

  typedef enum logic [1:0] {LIVRE = 2'd0, ESPERA = 2'd1, CARREGADO = 2'd2} slotEstado_t;

  typedef struct packed {
    slotEstado_t estado;
    logic [1:0]  origem;
    logic [1:0]  destino;
  } slot_t;

  estado_t            estado, estadoProx;
  slot_t              slots [N_SLOTS];
  slot_t              slotsProx [N_SLOTS];
  logic [N_SLOTS-1:0] mascaraCarga, mascaraCargaProx;
  logic [N_SLOTS-1:0] livre, selLivre, descarga, carga;
  logic [3:0]         paradas, ocupadosProx;
  logic [1:0]         proxParadaProx;
  logic               temDestinoProx, sobeProx, tiraProx, colocaProx;
  logic               aceitoProx, rejeitadoProx, pedidoValido, achouLivre;
  logic [2:0]         acima, abaixo;

  function automatic logic uniHot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [1:0] codifica(input logic [3:0] v);
    logic [1:0] r;
    case (v)
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // {found, floor} of the nearest stop strictly above / below the cab
  function automatic logic [2:0] maisProxAcima(input logic [3:0] p, input logic [1:0] a);
    logic [2:0] r;
    r = 3'd0;
    for (int f = 3; f >= 0; f--)
      if (f > int'(a) && p[f]) r = {1'b1, 2'(f)};
    return r;
  endfunction

  function automatic logic [2:0] maisProxAbaixo(input logic [3:0] p, input logic [1:0] a);
    logic [2:0] r;
    r = 3'd0;
    for (int f = 0; f < 4; f++)
      if (f < int'(a) && p[f]) r = {1'b1, 2'(f)};
    return r;
  endfunction

  // Stop map and per-slot match masks at the current floor
  always_comb begin
    paradas    = 4'd0;
    descarga   = '0;
    carga      = '0;
    livre      = '0;
    selLivre   = '0;
    achouLivre = 1'b0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      case (slots[i].estado)
        ESPERA: begin
          paradas[slots[i].origem] = 1'b1;
          carga[i] = (slots[i].origem == andarAtual);
        end
        CARREGADO: begin
          paradas[slots[i].destino] = 1'b1;
          descarga[i] = (slots[i].destino == andarAtual);
        end
        default: livre[i] = 1'b1;
      endcase
      if (livre[i] && !achouLivre) begin
        selLivre[i] = 1'b1;
        achouLivre  = 1'b1;
      end
    end
  end

  assign pedidoValido = uniHot(origemBot) && uniHot(destinoBot) && (origemBot != destinoBot);
  assign acima        = maisProxAcima(paradas, andarAtual);
  assign abaixo       = maisProxAbaixo(paradas, andarAtual);

  always_comb begin
    estadoProx       = estado;
    slotsProx        = slots;
    mascaraCargaProx = mascaraCarga;
    proxParadaProx   = proxParada;
    temDestinoProx   = temDestino;
    sobeProx         = sobe;
    aceitoProx       = 1'b0;
    rejeitadoProx    = 1'b0;
    ocupadosProx     = 4'd0;

    if (emergencia) begin
      estadoProx       = EMERG;
      temDestinoProx   = 1'b0;
      mascaraCargaProx = '0;
    end else begin
      case (estado)
        OCIOSO: begin
          temDestinoProx = 1'b0;
          if (paradas != 4'd0) estadoProx = DESPACHA;
        end
        DESPACHA: begin
          if (paradas == 4'd0) begin
            estadoProx = OCIOSO;
          end else begin
            if (paradas[andarAtual]) begin
              proxParadaProx = andarAtual;
            end else if (sobe) begin
              if (acima[2]) proxParadaProx = acima[1:0];
              else begin proxParadaProx = abaixo[1:0]; sobeProx = 1'b0; end
            end else begin
              if (abaixo[2]) proxParadaProx = abaixo[1:0];
              else begin proxParadaProx = acima[1:0]; sobeProx = 1'b1; end
            end
            temDestinoProx = 1'b1;
            estadoProx     = AGUARDA;
          end
        end
        AGUARDA: begin
          if (chegou && andarAtual == proxParada) estadoProx = TIRA;
        end
        TIRA: begin
          if (descarga == '0 || servico_feito) begin
            for (int i = 0; i < int'(N_SLOTS); i++)
              if (descarga[i]) slotsProx[i].estado = LIVRE;
            mascaraCargaProx = carga;
            estadoProx       = COLOCA;
          end
        end
        COLOCA: begin
          // Only slots latched on entry are served; late arrivals wait for the next dispatch
          if (mascaraCarga == '0 || servico_feito) begin
            for (int i = 0; i < int'(N_SLOTS); i++)
              if (mascaraCarga[i]) slotsProx[i].estado = CARREGADO;
            mascaraCargaProx = '0;
            temDestinoProx   = 1'b0;
            estadoProx       = OCIOSO;
          end
        end
        EMERG:   estadoProx = OCIOSO;
        default: estadoProx = OCIOSO;
      endcase
    end

    // Requests see only slots that were free before this cycle
    if (novo_pedido) begin
      if (pedidoValido && achouLivre && !emergencia && estado != EMERG) begin
        aceitoProx = 1'b1;
        for (int i = 0; i < int'(N_SLOTS); i++)
          if (selLivre[i])
            slotsProx[i] = '{estado: ESPERA, origem: codifica(origemBot), destino: codifica(destinoBot)};
      end else begin
        rejeitadoProx = 1'b1;
      end
    end

    for (int i = 0; i < int'(N_SLOTS); i++)
      if (slotsProx[i].estado != LIVRE) ocupadosProx = ocupadosProx + 4'd1;

    tiraProx   = (estadoProx == TIRA) && (descarga != '0);
    colocaProx = (estadoProx == COLOCA) && (mascaraCargaProx != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado           <= OCIOSO;
      mascaraCarga     <= '0;
      proxParada       <= 2'd0;
      temDestino       <= 1'b0;
      sobe             <= 1'b1;
      tira_objetos     <= 1'b0;
      coloca_objetos   <= 1'b0;
      pedido_aceito    <= 1'b0;
      pedido_rejeitado <= 1'b0;
      slots_ocupados   <= 4'd0;
      for (int i = 0; i < int'(N_SLOTS); i++)
        slots[i] <= '{estado: LIVRE, origem: 2'd0, destino: 2'd0};
    end else begin
      estado           <= estadoProx;
      mascaraCarga     <= mascaraCargaProx;
      proxParada       <= proxParadaProx;
      temDestino       <= temDestinoProx;
      sobe             <= sobeProx;
      tira_objetos     <= tiraProx;
      coloca_objetos   <= colocaProx;
      pedido_aceito    <= aceitoProx;
      pedido_rejeitado <= rejeitadoProx;
      slots_ocupados   <= ocupadosProx;
      for (int i = 0; i < int'(N_SLOTS); i++)
        slots[i] <= slotsProx[i];
    end
  end

  assign db_estado = {1'b0, estado};

endmodule
